vpu_cmd_queue: RTL and testbench
================================

VPU_CMD_QUEUE -- requirements
Module: vpu_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter VPU_OPCODE, default 8'h03, the opcode value routed to the VPU.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_cmd  input  128  command from the LCP; opcode in bits [127:120].
REQ-006 SHALL have ports in_valid  input  1 and in_ready  output  1, forming the upstream handshake.
REQ-007 SHALL have port vpu_cmd  output  128  command presented to the vector unit.
REQ-008 SHALL have ports vpu_cmd_valid  output  1 and vpu_cmd_ready  input  1, forming the downstream handshake.
REQ-009 SHALL have port vpu_cmd_done  input  1  one-cycle completion pulse from the vector unit.
REQ-010 SHALL have port flush  input  1  synchronous discard of all queued, not-yet-issued commands.
REQ-011 SHALL have ports level  output  $clog2(DEPTH)+1  entries queued, and busy  output  1  (level!=0 or state!=S_IDLE).
REQ-012 SHALL have port done_count  output  16  count of completed commands.
REQ-013 SHALL have ports err_opcode  output  1 and err_spurious  output  1, each a one-cycle error pulse.
REQ-014 SHALL have port busy_cycles  output  32  performance counter (see Configuration).

Function
REQ-015 SHALL drive in_ready = (level < DEPTH); a push occurs when in_valid && in_ready.
REQ-016 SHALL drop a pushed command whose in_cmd[127:120] != VPU_OPCODE, leave level unchanged, and pulse err_opcode in the following cycle.
REQ-017 SHALL apply the opcode check of REQ-016 before the FIFO write.
REQ-018 SHALL allow push and pop in the same cycle, leaving level unchanged.
REQ-019 SHALL keep in_ready low when full, even in a cycle that pops.
REQ-020 SHALL implement the FSM S_IDLE, S_ISSUE, S_WAIT_DONE.
REQ-021 S_IDLE SHALL move to S_ISSUE when level != 0 and flush is low; it SHALL register the FIFO head onto vpu_cmd and set vpu_cmd_valid on that edge.
REQ-022 S_ISSUE SHALL hold vpu_cmd and vpu_cmd_valid stable until vpu_cmd_ready is sampled high.
REQ-023 On the S_ISSUE handshake, the block SHALL pop the FIFO, clear vpu_cmd_valid on that edge, and move to S_WAIT_DONE.
REQ-024 S_WAIT_DONE SHALL return to S_IDLE on vpu_cmd_done and increment done_count, which wraps at 16'hFFFF to 0.
REQ-025 SHALL allow at most one command outstanding, so vpu_cmd_valid is never high in S_WAIT_DONE.
REQ-026 SHALL give minimum latency into an empty idle queue as: push at edge N, vpu_cmd_valid high after edge N+1.
REQ-027 SHALL sustain a best-case throughput of one command per 3 cycles plus VPU execution time.
REQ-028 SHALL ignore vpu_cmd_done outside S_WAIT_DONE and pulse err_spurious in the following cycle.
REQ-029 flush SHALL set level to 0 next cycle, take priority over a simultaneous push (the push is discarded), and not abort an S_ISSUE or S_WAIT_DONE command already presented.
REQ-030 SHALL wrap FIFO read and write pointers modulo DEPTH.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously set state=S_IDLE, empty the FIFO, and drive level=0, vpu_cmd_valid=0, vpu_cmd=0, done_count=0, err_opcode=0, err_spurious=0, busy_cycles=0, busy=0.
REQ-032 in_ready SHALL be 1 during and after reset.
REQ-033 Reset asserted mid-S_ISSUE or mid-S_WAIT_DONE SHALL abandon the command with no done_count change.

Configuration
REQ-034 With VPU_CMDQ_PERF_EN defined, busy_cycles SHALL increment every cycle the state is not S_IDLE and saturate at 32'hFFFFFFFF.
REQ-035 Without VPU_CMDQ_PERF_EN, busy_cycles SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
REQ-036 The FSM state encodings (2-bit) and the opcode field position constants SHALL reside in shared package tpu_vpu_pkg.
REQ-037 The FIFO storage and pointers SHALL be one sub-module, vpu_cmd_fifo (128-bit wide, DEPTH deep, registered outputs).

Verification
REQ-038 Push one cmd with opcode 8'h03 into an empty queue, ready=1 -> vpu_cmd_valid high after edge N+1; after done, done_count=1.
REQ-039 Push opcode 8'h05 -> err_opcode pulses once, level stays 0, vpu_cmd_valid never asserts.
REQ-040 Hold vpu_cmd_ready=0 and push 9 cmds with DEPTH=8 -> in_ready falls after 8 pushes with level=8; vpu_cmd stays stable.
REQ-041 Flush asserted with 4 queued and one in S_WAIT_DONE -> level=0; the outstanding done still yields done_count+1; no further issue.
REQ-042 Pulse vpu_cmd_done in S_IDLE -> err_spurious pulses and done_count is unchanged.
REQ-043 Preload done_count to 16'hFFFF and complete one command -> done_count=0; with VPU_CMDQ_PERF_EN, busy_cycles equals the measured non-idle cycles.

Source files
------------

// File: rtl/tpu_vpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_vpu_pkg
// Shared definitions for the VPU command path:
//   - CMD_W / OPC_*  : command width and opcode field position
//   - state_t        : 2-bit issue FSM encoding (S_IDLE, S_ISSUE, S_WAIT_DONE)
//   - get_opcode()   : extracts the opcode field from a command word
// -----------------------------------------------------------------------------
package tpu_vpu_pkg;

   localparam int CMD_W   = 128;
   localparam int OPC_MSB = 127;
   localparam int OPC_LSB = 120;
   localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   function automatic logic [OPC_W-1:0] get_opcode(input logic [CMD_W-1:0] cmd);
      return cmd[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/vpu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// vpu_cmd_fifo
// DEPTH-deep command FIFO with flop storage, registered occupancy count and
// pointers that wrap modulo DEPTH (DEPTH is a power of two).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   i_push      : write i_wdata (ignored when full)
//   i_wdata     : command to store
//   i_pop       : drop the head entry (ignored when empty)
//   i_flush     : synchronous discard of all entries; wins over push/pop
//   o_rdata     : current head entry, read straight from the storage flops
//   o_count     : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module vpu_cmd_fifo
   import tpu_vpu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = CMD_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_do_push;
   logic w_do_pop;

   assign w_do_push = i_push && (r_count != CNT_FULL) && !i_flush;
   assign w_do_pop  = i_pop  && (r_count != '0)       && !i_flush;

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/vpu_cmd_queue.sv
// -----------------------------------------------------------------------------
// vpu_cmd_queue
// Queues 128-bit commands from the LCP, keeps only those whose opcode equals
// VPU_OPCODE, and issues them one at a time to the vector unit, waiting for
// its completion pulse before issuing the next.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both high; the sender holds data and valid stable until then, and
// valid never depends combinationally on ready.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_cmd/in_valid/in_ready : upstream command, opcode in [127:120]
//   vpu_cmd/vpu_cmd_valid/vpu_cmd_ready : downstream command to the VPU
//   vpu_cmd_done        : one-cycle completion pulse from the VPU
//   flush               : discard queued, not-yet-issued commands
//   level               : entries queued
//   busy                : queue non-empty or FSM not idle
//   done_count          : completed commands, wraps at 16 bits
//   err_opcode          : pulse, a pushed command had a foreign opcode
//   err_spurious        : pulse, vpu_cmd_done arrived with nothing outstanding
//   busy_cycles         : non-idle cycle counter, saturating
//   dbg_state           : current FSM state
// Build option: define VPU_CMDQ_PERF_EN to build the busy_cycles counter;
// otherwise busy_cycles is tied to zero.
// -----------------------------------------------------------------------------
module vpu_cmd_queue
   import tpu_vpu_pkg::*;
#(
   parameter int         DEPTH      = 8,
   parameter logic [7:0] VPU_OPCODE = 8'h03
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CMD_W-1:0]         in_cmd,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [CMD_W-1:0]         vpu_cmd,
   output logic                     vpu_cmd_valid,
   input  logic                     vpu_cmd_ready,
   input  logic                     vpu_cmd_done,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy,
   output logic [15:0]              done_count,
   output logic                     err_opcode,
   output logic                     err_spurious,
   output logic [31:0]              busy_cycles,
   output logic [1:0]               dbg_state
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   state_t           r_state;
   logic [CMD_W-1:0] r_vpu_cmd;
   logic             r_vpu_cmd_valid;
   logic [15:0]      r_done_count;
   logic             r_err_opcode;
   logic             r_err_spurious;

   state_t           w_nxt_state;
   logic [CMD_W-1:0] w_nxt_cmd;
   logic             w_nxt_valid;
   logic             w_handshake;
   logic             w_done_evt;
   logic             w_push_attempt;
   logic             w_opc_ok;
   logic             w_fifo_push;
   logic [CMD_W-1:0] w_head;
   logic [AW:0]      w_level;

   // in_ready depends only on the registered level, so a pop in the same
   // cycle never re-opens a full queue.
   assign in_ready       = (w_level < LVL_FULL);
   assign w_push_attempt = in_valid && in_ready;
   assign w_opc_ok       = (get_opcode(in_cmd) == VPU_OPCODE);
   // Foreign opcodes are filtered here, before the storage write.
   assign w_fifo_push    = w_push_attempt && w_opc_ok && !flush;

   vpu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_fifo_push),
      .i_wdata (in_cmd),
      .i_pop   (w_handshake),
      .i_flush (flush),
      .o_rdata (w_head),
      .o_count (w_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_vpu_cmd       <= '0;
         r_vpu_cmd_valid <= 1'b0;
      end else begin
         r_state         <= w_nxt_state;
         r_vpu_cmd       <= w_nxt_cmd;
         r_vpu_cmd_valid <= w_nxt_valid;
      end
   end

   // The head stays in the FIFO until the VPU accepts it, so a flush during
   // S_ISSUE clears the queue but the presented copy in r_vpu_cmd completes.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cmd   = r_vpu_cmd;
      w_nxt_valid = r_vpu_cmd_valid;
      w_handshake = 1'b0;
      w_done_evt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((w_level != '0) && !flush) begin
               w_nxt_state = S_ISSUE;
               w_nxt_cmd   = w_head;
               w_nxt_valid = 1'b1;
            end
         end
         S_ISSUE: begin
            if (vpu_cmd_ready) begin
               w_handshake = 1'b1;
               w_nxt_valid = 1'b0;
               w_nxt_state = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (vpu_cmd_done) begin
               w_done_evt  = 1'b1;
               w_nxt_state = S_IDLE;
            end
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done_count   <= '0;
         r_err_opcode   <= 1'b0;
         r_err_spurious <= 1'b0;
      end else begin
         if (w_done_evt) r_done_count <= r_done_count + 16'd1;
         r_err_opcode   <= w_push_attempt && !w_opc_ok;
         r_err_spurious <= vpu_cmd_done && (r_state != S_WAIT_DONE);
      end
   end

`ifdef VPU_CMDQ_PERF_EN
   logic [31:0] r_busy_cycles;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy_cycles <= '0;
      end else if ((r_state != S_IDLE) && (r_busy_cycles != 32'hFFFF_FFFF)) begin
         r_busy_cycles <= r_busy_cycles + 32'd1;
      end
   end

   assign busy_cycles = r_busy_cycles;
`else
   assign busy_cycles = 32'd0;
`endif

   assign vpu_cmd       = r_vpu_cmd;
   assign vpu_cmd_valid = r_vpu_cmd_valid;
   assign level         = w_level;
   assign busy          = (w_level != '0) || (r_state != S_IDLE);
   assign done_count    = r_done_count;
   assign err_opcode    = r_err_opcode;
   assign err_spurious  = r_err_spurious;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_vpu_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_vpu_cmd_queue
// Directed sequence with randomized command payloads and timing, checked
// against a queue-based model of the command stream.
// -----------------------------------------------------------------------------
module tb_vpu_cmd_queue;

   localparam int         DEPTH = 8;
   localparam logic [7:0] OPC   = 8'h03;

   logic         clk;
   logic         rst_n;
   logic [127:0] in_cmd;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] vpu_cmd;
   logic         vpu_cmd_valid;
   logic         vpu_cmd_ready;
   logic         vpu_cmd_done;
   logic         flush;
   logic [3:0]   level;
   logic         busy;
   logic [15:0]  done_count;
   logic         err_opcode;
   logic         err_spurious;
   logic [31:0]  busy_cycles;
   logic [1:0]   dbg_state;

   int           checks   = 0;
   int           failures = 0;
   logic [127:0] exp_q[$];
   logic [15:0]  model_done;
   int unsigned  model_busy;
   bit           outst;

   vpu_cmd_queue #(
      .DEPTH      (DEPTH),
      .VPU_OPCODE (OPC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_cmd        (in_cmd),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .vpu_cmd       (vpu_cmd),
      .vpu_cmd_valid (vpu_cmd_valid),
      .vpu_cmd_ready (vpu_cmd_ready),
      .vpu_cmd_done  (vpu_cmd_done),
      .flush         (flush),
      .level         (level),
      .busy          (busy),
      .done_count    (done_count),
      .err_opcode    (err_opcode),
      .err_spurious  (err_spurious),
      .busy_cycles   (busy_cycles),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Engine is busy while a command is presented or accepted-but-not-done.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_busy = 0;
         outst      = 1'b0;
      end else begin
         if (vpu_cmd_valid || outst) model_busy++;
         if (vpu_cmd_valid && vpu_cmd_ready) outst = 1'b1;
         else if (vpu_cmd_done) outst = 1'b0;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rand_cmd(input bit good);
      logic [127:0] c;
      logic [7:0]   op;
      c = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (good) begin
         op = OPC;
      end else begin
         op = 8'($urandom_range(0, 255));
         if (op == OPC) op = 8'h05;
      end
      c[127:120] = op;
      return c;
   endfunction

   // One-cycle push attempt with the VPU side idle (no pop this cycle).
   task automatic push(input logic [127:0] c);
      bit acc;
      bit good;
      good = (c[127:120] == OPC);
      acc  = (exp_q.size() < DEPTH);
      check("in_ready_pre", in_ready, acc);
      in_cmd   = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (acc && good) exp_q.push_back(c);
      check("err_opcode", err_opcode, acc && !good);
      check("level", level, exp_q.size());
   endtask

   // Take the next command through issue, handshake and completion.
   task automatic serve_one();
      int n;
      logic [127:0] head;
      n    = 0;
      head = exp_q[0];
      while (!vpu_cmd_valid && n < 20) begin
         tick();
         n++;
      end
      check("valid_timeout", vpu_cmd_valid, 1'b1);
      check("vpu_cmd", vpu_cmd, head);
      repeat ($urandom_range(0, 3)) begin
         tick();
         check("cmd_stable", vpu_cmd, head);
         check("valid_hold", vpu_cmd_valid, 1'b1);
      end
      vpu_cmd_ready = 1'b1;
      tick();
      vpu_cmd_ready = 1'b0;
      void'(exp_q.pop_front());
      check("valid_clr", vpu_cmd_valid, 1'b0);
      check("level_pop", level, exp_q.size());
      repeat ($urandom_range(0, 3)) begin
         tick();
         check("one_outstanding", vpu_cmd_valid, 1'b0);
      end
      vpu_cmd_done = 1'b1;
      tick();
      vpu_cmd_done = 1'b0;
      model_done++;
      check("done_count", done_count, model_done);
      check("no_spurious", err_spurious, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [127:0] c;

      rst_n         = 1'b0;
      in_cmd        = '0;
      in_valid      = 1'b0;
      vpu_cmd_ready = 1'b0;
      vpu_cmd_done  = 1'b0;
      flush         = 1'b0;
      model_done    = '0;

      // reset values
      #3;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_level", level, 0);
      check("rst_valid", vpu_cmd_valid, 1'b0);
      check("rst_cmd", vpu_cmd, 0);
      check("rst_done_count", done_count, 0);
      check("rst_busy", busy, 1'b0);
      check("rst_errs", {err_opcode, err_spurious}, 0);
      check("rst_busy_cycles", busy_cycles, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", in_ready, 1'b1);

      // minimum latency: push at edge N, valid after edge N+1
      push(rand_cmd(1'b1));
      check("lat_n_valid", vpu_cmd_valid, 1'b0);
      check("lat_n_busy", busy, 1'b1);
      tick();
      check("lat_n1_valid", vpu_cmd_valid, 1'b1);
      serve_one();
      check("idle_busy", busy, 1'b0);

      // foreign opcode dropped
      push(rand_cmd(1'b0));
      tick();
      check("err_opcode_once", err_opcode, 1'b0);
      check("bad_level", level, 0);
      repeat (3) begin
         tick();
         check("bad_no_issue", vpu_cmd_valid, 1'b0);
      end

      // fill to DEPTH with ready held low, then one more
      for (int i = 0; i < DEPTH + 1; i++) push(rand_cmd(1'b1));
      check("full_level", level, DEPTH);
      check("full_in_ready", in_ready, 1'b0);
      check("full_valid", vpu_cmd_valid, 1'b1);
      check("full_cmd", vpu_cmd, exp_q[0]);

      // full and popping: in_ready stays low, offered command is not taken
      in_cmd        = rand_cmd(1'b1);
      in_valid      = 1'b1;
      vpu_cmd_ready = 1'b1;
      check("full_pop_in_ready", in_ready, 1'b0);
      tick();
      in_valid      = 1'b0;
      vpu_cmd_ready = 1'b0;
      void'(exp_q.pop_front());
      check("full_pop_level", level, DEPTH - 1);
      vpu_cmd_done = 1'b1;
      tick();
      vpu_cmd_done = 1'b0;
      model_done++;
      check("full_done", done_count, model_done);

      // simultaneous push and pop keeps level
      tick();
      check("pp_valid", vpu_cmd_valid, 1'b1);
      check("pp_cmd", vpu_cmd, exp_q[0]);
      c             = rand_cmd(1'b1);
      in_cmd        = c;
      in_valid      = 1'b1;
      vpu_cmd_ready = 1'b1;
      check("pp_in_ready", in_ready, 1'b1);
      tick();
      in_valid      = 1'b0;
      vpu_cmd_ready = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(c);
      check("pp_level", level, exp_q.size());
      vpu_cmd_done = 1'b1;
      tick();
      vpu_cmd_done = 1'b0;
      model_done++;
      check("pp_done", done_count, model_done);
      while (exp_q.size() != 0) serve_one();

      // randomized bursts, mixed opcodes (pointer wrap is exercised)
      repeat (12) begin
         int k;
         k = $urandom_range(1, 4);
         for (int j = 0; j < k; j++) push(rand_cmd($urandom_range(0, 3) != 0));
         while (exp_q.size() != 0) serve_one();
      end

      // flush with 4 queued and one outstanding, plus a push in the flush cycle
      for (int i = 0; i < 5; i++) push(rand_cmd(1'b1));
      vpu_cmd_ready = 1'b1;
      tick();
      vpu_cmd_ready = 1'b0;
      void'(exp_q.pop_front());
      check("fl_pre_level", level, 4);
      flush    = 1'b1;
      in_cmd   = rand_cmd(1'b1);
      in_valid = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      check("fl_level", level, 0);
      check("fl_busy", busy, 1'b1);
      vpu_cmd_done = 1'b1;
      tick();
      vpu_cmd_done = 1'b0;
      model_done++;
      check("fl_done", done_count, model_done);
      repeat (4) begin
         tick();
         check("fl_no_issue", vpu_cmd_valid, 1'b0);
      end
      check("fl_idle", busy, 1'b0);

      // spurious completion in idle
      vpu_cmd_done = 1'b1;
      tick();
      vpu_cmd_done = 1'b0;
      check("spur_pulse", err_spurious, 1'b1);
      check("spur_count", done_count, model_done);
      tick();
      check("spur_clear", err_spurious, 1'b0);

      // reset while a command is outstanding
      push(rand_cmd(1'b1));
      tick();
      vpu_cmd_ready = 1'b1;
      tick();
      vpu_cmd_ready = 1'b0;
      rst_n = 1'b0;
      #2;
      exp_q.delete();
      model_done = '0;
      check("mid_rst_count", done_count, 0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      vpu_cmd_done = 1'b1;
      tick();
      vpu_cmd_done = 1'b0;
      check("mid_rst_abandon", done_count, 0);
      check("mid_rst_spur", err_spurious, 1'b1);

      // done_count wrap from 16'hFFFF
      dut.r_done_count = 16'hFFFF;
      model_done       = 16'hFFFF;
      push(rand_cmd(1'b1));
      serve_one();
      check("wrap_count", done_count, 16'h0000);
`ifdef VPU_CMDQ_PERF_EN
      check("busy_cycles", busy_cycles, model_busy);
`else
      check("busy_cycles_off", busy_cycles, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
